// File: rtl/vga_pio_port_if.sv
// rtl/vga_pio_port_if.sv - Avalon-MM slave bus bundle for vga_pio_port
// Ports (signals):
//   address    [2:0]  word address, driven by master
//   chipselect        slave select (qualifies writes), driven by master
//   write_n           active-low write strobe, driven by master
//   writedata  [31:0] write data, driven by master
//   readdata   [31:0] zero-wait-state read data, driven by slave
interface vga_pio_port_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/vga_pio_port.sv
// rtl/vga_pio_port.sv - parametrised Avalon-MM PIO with set/clear output and edge-capture input
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   bus       vga_pio_port_if slave (address/chipselect/write_n/writedata/readdata)
//   in_port   asynchronous external inputs, WIDTH bits
//   out_port  registered output data, WIDTH bits
//   irq       level interrupt, high while any masked-in captured edge is pending
// Register map: 0 OUT_DATA, 1 OUT_SET, 2 OUT_CLR, 3 IN_DATA, 4 IRQ_MASK, 5 EDGE_CAP (W1C).
module vga_pio_port #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_MODE   = 0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    vga_pio_port_if.slave    bus,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);
    // Edge detection stays off until the synchroniser and prev register
    // have been refilled with real input levels after reset.
    localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;   // [0] newest, [SYNC_STAGES-1] settled
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] detected;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] cap_clr;
    logic [2:0]       arm_cnt;
    logic             armed;
    logic             wr_en;
    logic [31:0]      readdata_c;

    assign wr_en   = bus.chipselect && !bus.write_n;
    assign wdata   = bus.writedata[WIDTH-1:0];
    assign in_sync = sync_q[SYNC_STAGES-1];
    assign armed   = (arm_cnt == ARM_DONE);
    assign rise    = in_sync & ~prev_q;
    assign fall    = ~in_sync & prev_q;
    assign cap_clr = (wr_en && bus.address == 3'd5) ? wdata : '0;

    always_comb begin
        detected = '0;
        if (armed) begin
            if (EDGE_MODE == 0)
                detected = rise;
            else if (EDGE_MODE == 1)
                detected = fall;
            else
                detected = rise | fall;    // 2 and any larger value: both edges
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            prev_q  <= '0;
            arm_cnt <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
            prev_q <= in_sync;
            if (!armed)
                arm_cnt <= arm_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= RESET_VALUE;
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            if (wr_en) begin
                case (bus.address)
                    3'd0:    out_port <= wdata;
                    3'd1:    out_port <= out_port | wdata;
                    3'd2:    out_port <= out_port & ~wdata;
                    3'd4:    irq_mask <= wdata;
                    default: ;
                endcase
            end
            // Clear first, then OR in new edges so a coincident edge survives.
            edge_cap <= (edge_cap & ~cap_clr) | detected;
        end
    end

    always_comb begin
        readdata_c = '0;
        case (bus.address)
            3'd0:    readdata_c[WIDTH-1:0] = out_port;
            3'd3:    readdata_c[WIDTH-1:0] = in_sync;
            3'd4:    readdata_c[WIDTH-1:0] = irq_mask;
            3'd5:    readdata_c[WIDTH-1:0] = edge_cap;
            default: readdata_c = '0;
        endcase
    end

    assign bus.readdata = readdata_c;
    assign irq          = |(edge_cap & irq_mask);
endmodule

// File: tb/tb_vga_pio_port.sv
// tb/tb_vga_pio_port.sv - randomized self-checking bench for vga_pio_port against a history-based model
module tb_vga_pio_port;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vga_pio_port_if bus0();
    vga_pio_port_if bus1();

    logic [31:0] in0, out0;
    logic [7:0]  in1, out1;
    logic        irq0, irq1;

    vga_pio_port #(.WIDTH(32), .RESET_VALUE(32'hA5), .EDGE_MODE(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0.slave),
        .in_port(in0), .out_port(out0), .irq(irq0)
    );

    vga_pio_port #(.WIDTH(8), .RESET_VALUE(8'h3C), .EDGE_MODE(2), .SYNC_STAGES(3)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.slave),
        .in_port(in1), .out_port(out1), .irq(irq1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Per-instance parameters as seen by the model.
    function automatic int p_sync(int d);  return (d != 0) ? 3 : 2; endfunction
    function automatic int p_mode(int d);  return (d != 0) ? 2 : 0; endfunction
    function automatic logic [31:0] p_wmask(int d); return (d != 0) ? 32'hFF : 32'hFFFF_FFFF; endfunction
    function automatic logic [31:0] p_reset(int d); return (d != 0) ? 32'h3C : 32'hA5; endfunction

    // Model: registers plus a history of in_port samples, newest first.
    logic [31:0] m_out [2];
    logic [31:0] m_mask[2];
    logic [31:0] m_cap [2];
    int          m_cnt [2];
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    // Stimulus for each instance.
    logic [2:0]  s_addr[2];
    logic        s_cs  [2];
    logic        s_wn  [2];
    logic [31:0] s_wd  [2];
    logic [31:0] s_in  [2];

    // Input sample taken i edges ago; before reset release everything reads 0.
    function automatic logic [31:0] hist(int d, int i);
        if (d == 0) return (i < q0.size()) ? q0[i] : 32'h0;
        return (i < q1.size()) ? q1[i] : 32'h0;
    endfunction

    function automatic void model_reset(int d);
        m_out[d]  = p_reset(d);
        m_mask[d] = 32'h0;
        m_cap[d]  = 32'h0;
        m_cnt[d]  = 0;
        if (d == 0) q0.delete(); else q1.delete();
    endfunction

    function automatic void model_step(int d);
        int          s;
        logic [31:0] now_v, old_v, det, wm, wd, clr;
        s     = p_sync(d);
        wm    = p_wmask(d);
        now_v = hist(d, s - 1);
        old_v = hist(d, s);
        case (p_mode(d))
            0:       det = now_v & ~old_v;
            1:       det = ~now_v & old_v;
            default: det = now_v ^ old_v;
        endcase
        if (m_cnt[d] < s + 1) det = 32'h0;
        det = det & wm;
        wd  = s_wd[d] & wm;
        clr = 32'h0;
        if (s_cs[d] && !s_wn[d]) begin
            case (s_addr[d])
                3'd0: m_out[d]  = wd;
                3'd1: m_out[d]  = m_out[d] | wd;
                3'd2: m_out[d]  = m_out[d] & ~wd;
                3'd4: m_mask[d] = wd;
                3'd5: clr       = wd;
                default: ;
            endcase
        end
        m_cap[d] = (m_cap[d] & ~clr) | det;
        if (d == 0) begin
            q0.push_front(s_in[0] & wm);
            if (q0.size() > 8) void'(q0.pop_back());
        end else begin
            q1.push_front(s_in[1] & wm);
            if (q1.size() > 8) void'(q1.pop_back());
        end
        if (m_cnt[d] < 16) m_cnt[d]++;
    endfunction

    function automatic logic [31:0] exp_rd(int d);
        case (s_addr[d])
            3'd0:    return m_out[d];
            3'd3:    return hist(d, p_sync(d) - 1);
            3'd4:    return m_mask[d];
            3'd5:    return m_cap[d];
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive();
        bus0.address    = s_addr[0];
        bus0.chipselect = s_cs[0];
        bus0.write_n    = s_wn[0];
        bus0.writedata  = s_wd[0];
        bus1.address    = s_addr[1];
        bus1.chipselect = s_cs[1];
        bus1.write_n    = s_wn[1];
        bus1.writedata  = s_wd[1];
        in0 = s_in[0];
        in1 = s_in[1][7:0];
    endtask

    task automatic check_now();
        check_eq($sformatf("rd0_a%0d", s_addr[0]), bus0.readdata, exp_rd(0));
        check_eq($sformatf("rd1_a%0d", s_addr[1]), bus1.readdata, exp_rd(1));
        check_eq("out0", out0, m_out[0]);
        check_eq("out1", {24'h0, out1}, m_out[1]);
        check_eq("irq0", {31'h0, irq0}, {31'h0, |(m_cap[0] & m_mask[0])});
        check_eq("irq1", {31'h0, irq1}, {31'h0, |(m_cap[1] & m_mask[1])});
    endtask

    // Entered just after a falling edge; returns at the next falling edge.
    task automatic do_cycle();
        drive();
        #1;
        check_now();
        @(posedge clk);
        if (reset_n) begin
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
    endtask

    task automatic do_write(input int d, input logic [2:0] a, input logic [31:0] data);
        s_addr[d] = a;
        s_cs[d]   = 1'b1;
        s_wn[d]   = 1'b0;
        s_wd[d]   = data;
        do_cycle();
        s_cs[d]   = 1'b0;
        s_wn[d]   = 1'b1;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            s_addr[d] = 3'd0;
            s_cs[d]   = 1'b0;
            s_wn[d]   = 1'b1;
            s_wd[d]   = 32'h0;
            model_reset(d);
        end
        s_in[0] = 32'hFFFF_FFFF;
        s_in[1] = 32'hFF;
        drive();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_out0", out0, 32'hA5);
        check_eq("rst_out1", {24'h0, out1}, 32'h3C);
        check_eq("rst_irq0", {31'h0, irq0}, 32'h0);
        check_eq("rst_rd0", bus0.readdata, 32'hA5);

        // Inputs high through reset: no capture during the settling window.
        reset_n = 1'b1;
        s_addr[0] = 3'd5;
        s_addr[1] = 3'd5;
        repeat (20) do_cycle();
        check_eq("arm_quiet0", bus0.readdata, 32'h0);
        check_eq("arm_quiet1", bus1.readdata, 32'h0);

        // Plain / set / clear writes.
        do_write(0, 3'd0, 32'h0000_00F0);
        check_eq("out_data", out0, 32'hF0);
        do_write(0, 3'd1, 32'h0000_000F);
        check_eq("out_set", out0, 32'hFF);
        check_eq("rd_set_zero", bus0.readdata, 32'h0);
        do_write(0, 3'd2, 32'h0000_0030);
        check_eq("out_clr", out0, 32'hCF);
        check_eq("rd_clr_zero", bus0.readdata, 32'h0);

        // Narrow instance truncates writes; unused addresses read 0.
        do_write(1, 3'd0, 32'hFFFF_FF12);
        check_eq("w8_out", {24'h0, out1}, 32'h12);
        check_eq("w8_rd", bus1.readdata, 32'h12);
        s_addr[1] = 3'd6;
        do_cycle();
        check_eq("w8_rd6", bus1.readdata, 32'h0);

        // Rising-edge instance: falling inputs capture nothing.
        do_write(0, 3'd4, 32'h1);
        s_in[0] = 32'h0;
        repeat (5) do_cycle();
        s_addr[0] = 3'd5;
        do_cycle();
        check_eq("fall_ignored", bus0.readdata, 32'h0);
        s_in[0] = 32'h1;
        do_cycle();
        do_cycle();
        check_eq("irq_early", {31'h0, irq0}, 32'h0);
        do_cycle();
        check_eq("irq_rise", {31'h0, irq0}, 32'h1);
        check_eq("cap_rise", bus0.readdata, 32'h1);
        do_write(0, 3'd5, 32'h1);
        check_eq("irq_w1c", {31'h0, irq0}, 32'h0);

        // Clear coincident with a fresh detection: the capture wins.
        s_in[0] = 32'h0;
        repeat (4) do_cycle();
        s_in[0] = 32'h1;
        do_cycle();
        do_cycle();
        do_write(0, 3'd5, 32'h1);
        check_eq("cap_set_wins", bus0.readdata, 32'h1);
        check_eq("irq_set_wins", {31'h0, irq0}, 32'h1);

        // Any-edge instance with mask off, then mask on.
        s_addr[1] = 3'd5;
        s_in[1]   = 32'hF7;
        repeat (4) do_cycle();
        check_eq("any_cap", bus1.readdata, 32'h8);
        check_eq("any_irq_masked", {31'h0, irq1}, 32'h0);
        do_write(1, 3'd4, 32'h8);
        check_eq("any_irq_on", {31'h0, irq1}, 32'h1);

        // Asynchronous reset mid-cycle.
        s_addr[1] = 3'd5;
        drive();
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("arst_irq1", {31'h0, irq1}, 32'h0);
        check_eq("arst_cap1", bus1.readdata, 32'h0);
        check_eq("arst_irq0", {31'h0, irq0}, 32'h0);
        check_eq("arst_cap0", bus0.readdata, 32'h0);
        model_reset(0);
        model_reset(1);
        do_cycle();
        reset_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 2; d++) begin
                s_addr[d] = 3'($urandom_range(0, 7));
                s_cs[d]   = 1'($urandom_range(0, 1));
                s_wn[d]   = 1'($urandom_range(0, 1));
                s_wd[d]   = ($urandom_range(0, 1) != 0) ? $urandom : (32'h1 << $urandom_range(0, 31));
                if ($urandom_range(0, 3) == 0) s_in[d] = $urandom;
            end
            if (i == 200) begin
                reset_n = 1'b0;
                model_reset(0);
                model_reset(1);
                do_cycle();
                do_cycle();
                reset_n = 1'b1;
            end
            do_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
